if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline; consumes the next-PC redirect from branch/jump resolution.
//  Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
//  Delivers {pc, instruction} to decode through the IF/ID register, with stall, flush and a one-entry skid buffer.
//  Discards fetches invalidated by a redirect.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC of first fetch after reset
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  redirect_valid  in   1   taken branch/jump/jr this cycle; flush IF and refetch
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 2'b00)
//  id_stall        in   1   decode cannot accept an instruction this cycle
//  imem_req        out  1   fetch request
//  imem_addr       out  32  fetch word address
//  imem_ack        in   1   memory returns imem_rdata this cycle (may be same cycle as req)
//  imem_rdata      in   32  fetched instruction
//  if_valid        out  1   IF/ID register holds a live instruction
//  if_pc           out  32  PC of if_ir
//  if_pc4          out  32  if_pc + 4 (jal link value)
//  if_ir           out  32  instruction to decode
// BEHAVIOUR
//  Reset: state=IDLE, pc=fetch_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_ir=0, buffer empty.
//   imem_req=0, imem_addr=RESET_PC. Async assert clears everything immediately, incl. mid-transaction.
//  imem_addr = fetch_addr register; imem_req = (state==FETCH || state==DRAIN). All outputs are registered or state-decoded.
//  slot_free = !if_valid || !id_stall (IF/ID empty or drained this cycle).
//  States:
//   IDLE: one cycle after reset release -> FETCH.
//   FETCH: req=1 at fetch_addr.
//    - ack & slot_free: IF/ID <= {fetch_addr, rdata}, if_valid=1; pc, fetch_addr += 4; stay FETCH (back-to-back).
//    - ack & !slot_free: rdata into buffer; pc += 4 -> WAIT_SLOT.
//    - no ack: hold.
//   WAIT_SLOT: req=0. When slot_free: buffer -> IF/ID, fetch_addr=pc -> FETCH.
//   DRAIN: req=1, fetch_addr held at stale address. On ack: data dropped, fetch_addr=pc -> FETCH.
//  Handshake: while req=1 and no ack, imem_addr must not change. Every accepted ack consumes exactly one request.
//  ID consumes when if_valid & !id_stall. if_valid drops next cycle unless a new instruction loads the same edge.
//  Redirect (priority over all except rst): pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0; buffer cleared.
//   - FETCH, no ack: -> DRAIN.
//   - FETCH, ack this cycle: data dropped; fetch_addr=target, stay FETCH.
//   - WAIT_SLOT/IDLE: fetch_addr=target -> FETCH.
//   - DRAIN: pc updated (latest wins); still wait for ack.
//  Arithmetic: PC increments wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). if_pc4 = if_pc + 4, same wrap.
//  Throughput: zero-wait memory (ack same cycle) gives 1 instr/cycle. First req on the 2nd cycle after rst release.
// TESTING
//  1. rst release, ack=1 always, id_stall=0 -> imem_addr 0x3000,0x3004,0x3008 in consecutive req cycles;
//     if_pc/if_ir follow 1 cycle later, if_pc4=if_pc+4.
//  2. id_stall=1 for 3 cycles while IF/ID holds 0x3004, ack=1 -> 0x3008 buffered, req=0;
//     after release 0x3004 then 0x3008 reach ID, no loss or duplicate; next req 0x300C.
//  3. redirect to 0x3100 while req at 0x3010 outstanding, ack after 3 cycles -> imem_addr stays 0x3010 until ack,
//     data dropped, if_valid=0 meanwhile, next req 0x3100.
//  4. redirect (0x3100) same cycle as ack of 0x3010 -> if_valid=0 next cycle, next req 0x3100.
//     redirect_pc=0x3103 -> fetch 0x3100.
//  5. redirect to 0xFFFF_FFFC, ack=1 -> next fetch 0x0000_0000; if_pc4 of that instr = 0x0000_0000.
//  6. assert rst during DRAIN -> imem_req=0, if_valid=0 immediately; after release first req at 0x3000, stale ack ignored.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the architectural PC, fetches words over a req/ack
// handshake and feeds the IF/ID register through a one-entry skid buffer.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic [31:0] if_ir
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] fetch_addr, fetch_addr_nxt;
   logic [31:0] buf_ir, buf_ir_nxt;
   logic        if_valid_nxt;
   logic [31:0] if_pc_nxt, if_pc4_nxt, if_ir_nxt;

   logic [31:0] target;
   logic        slot_free;

   assign target    = {redirect_pc[31:2], 2'b00};
   assign slot_free = !if_valid || !id_stall;

   assign imem_req  = (state == FETCH) || (state == DRAIN);
   assign imem_addr = fetch_addr;

   always_comb begin
      // NOTE: every next-state variable gets a hold default first, so no path can infer a latch.
      state_nxt      = state;
      pc_nxt         = pc;
      fetch_addr_nxt = fetch_addr;
      buf_ir_nxt     = buf_ir;
      if_pc_nxt      = if_pc;
      if_pc4_nxt     = if_pc4;
      if_ir_nxt      = if_ir;
      // Decode drains the IF/ID entry; a load below overrides this.
      if_valid_nxt   = if_valid && id_stall;

      unique case (state)
         IDLE: begin
            state_nxt = FETCH;
            if (redirect_valid) begin
               pc_nxt         = target;
               fetch_addr_nxt = target;
               if_valid_nxt   = 1'b0;
            end
         end

         FETCH: begin
            if (redirect_valid) begin
               pc_nxt       = target;
               if_valid_nxt = 1'b0;
               if (imem_ack) fetch_addr_nxt = target;
               else          state_nxt      = DRAIN;
            end else if (imem_ack) begin
               pc_nxt = pc + 32'd4;
               if (slot_free) begin
                  if_valid_nxt   = 1'b1;
                  if_pc_nxt      = fetch_addr;
                  if_pc4_nxt     = fetch_addr + 32'd4;
                  if_ir_nxt      = imem_rdata;
                  fetch_addr_nxt = fetch_addr + 32'd4;
               end else begin
                  // fetch_addr keeps the buffered word's PC until it moves to IF/ID.
                  buf_ir_nxt = imem_rdata;
                  state_nxt  = WAIT_SLOT;
               end
            end
         end

         WAIT_SLOT: begin
            if (redirect_valid) begin
               pc_nxt         = target;
               fetch_addr_nxt = target;
               if_valid_nxt   = 1'b0;
               state_nxt      = FETCH;
            end else if (slot_free) begin
               if_valid_nxt   = 1'b1;
               if_pc_nxt      = fetch_addr;
               if_pc4_nxt     = fetch_addr + 32'd4;
               if_ir_nxt      = buf_ir;
               fetch_addr_nxt = pc;
               state_nxt      = FETCH;
            end
         end

         DRAIN: begin
            if (redirect_valid) begin
               pc_nxt       = target;
               if_valid_nxt = 1'b0;
            end
            // The outstanding request completes at its stale address; its data is dropped.
            if (imem_ack) begin
               fetch_addr_nxt = redirect_valid ? target : pc;
               state_nxt      = FETCH;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         fetch_addr <= RESET_PC;
         buf_ir     <= 32'd0;
         if_valid   <= 1'b0;
         if_pc      <= RESET_PC;
         if_pc4     <= RESET_PC + 32'd4;
         if_ir      <= 32'd0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         fetch_addr <= fetch_addr_nxt;
         buf_ir     <= buf_ir_nxt;
         if_valid   <= if_valid_nxt;
         if_pc      <= if_pc_nxt;
         if_pc4     <= if_pc4_nxt;
         if_ir      <= if_ir_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a queue-based model of fetched-but-unconsumed words.
module tb_if_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic [31:0] if_ir;
   logic [31:0] salt;

   int n_vec = 0;
   int n_err = 0;

   if_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pc4         (if_pc4),
      .if_ir          (if_ir)
   );

   always #5 clk = ~clk;

   // Zero-wait memory: the word is a fixed function of its address (salt = 0 in directed tests).
   assign imem_rdata = {imem_addr[15:0], imem_addr[31:16]} ^ salt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Model: q holds delivered words not yet consumed (head = IF/ID, second = skid buffer).
   // A fetch is requested whenever fewer than two words are held; a redirect with a request
   // outstanding leaves one stale request whose ack is swallowed.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
   } item_t;

   item_t       q[$];
   bit          m_started;
   bit          m_stale;
   bit          model_on = 1'b0;
   logic [31:0] m_pc;
   logic [31:0] m_stale_addr;

   function automatic bit m_req();
      return m_started && (q.size() < 2);
   endfunction

   function automatic logic [31:0] m_addr();
      return m_stale ? m_stale_addr : m_pc;
   endfunction

   task automatic model_reset();
      q.delete();
      m_started    = 1'b0;
      m_stale      = 1'b0;
      m_pc         = RESET_PC;
      m_stale_addr = RESET_PC;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      bit          req;
      bit          consume;
      item_t       it;
      tgt = {redirect_pc[31:2], 2'b00};
      if (!m_started) begin
         m_started = 1'b1;
         if (redirect_valid) m_pc = tgt;
         return;
      end
      req     = m_req();
      consume = (q.size() > 0) && !id_stall;
      if (redirect_valid) begin
         if (req && !imem_ack) begin
            m_stale_addr = m_addr();
            m_stale      = 1'b1;
         end else if (req && imem_ack) begin
            m_stale = 1'b0;
         end
         q.delete();
         m_pc = tgt;
      end else begin
         if (consume) void'(q.pop_front());
         if (req && imem_ack) begin
            if (m_stale) begin
               m_stale = 1'b0;
            end else begin
               it.pc = m_pc;
               it.ir = imem_rdata;
               q.push_back(it);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("if_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
         check("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
         if (m_req()) check("imem_addr", imem_addr, m_addr());
         if (q.size() > 0) begin
            check("if_pc", if_pc, q[0].pc);
            check("if_ir", if_ir, q[0].ir);
            check("if_pc4", if_pc4, q[0].pc + 32'd4);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      imem_ack       = 1'b0;
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      salt           = 32'd0;
      model_reset();
      #1;
      model_on = 1'b1;
      check("rst req",   {31'd0, imem_req}, 32'd0);
      check("rst valid", {31'd0, if_valid}, 32'd0);
      check("rst addr",  imem_addr, 32'h0000_3000);
      check("rst if_pc", if_pc, 32'h0000_3000);
      check("rst if_ir", if_ir, 32'd0);

      // Back-to-back fetch with zero-wait memory.
      step();
      imem_ack = 1'b1;
      rst      = 1'b0;
      step(); // IDLE -> FETCH
      check("t1 req",  {31'd0, imem_req}, 32'd1);
      check("t1 addr0", imem_addr, 32'h0000_3000);
      check("t1 novalid", {31'd0, if_valid}, 32'd0);
      step();
      check("t1 addr1", imem_addr, 32'h0000_3004);
      check("t1 pc0", if_pc, 32'h0000_3000);
      check("t1 ir0", if_ir, 32'h3000_0000);
      check("t1 pc4", if_pc4, 32'h0000_3004);
      step();
      check("t1 addr2", imem_addr, 32'h0000_3008);
      check("t1 pc1", if_pc, 32'h0000_3004);

      // Stall with 0x3004 in IF/ID: 0x3008 lands in the skid buffer.
      id_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2 noreq", {31'd0, imem_req}, 32'd0);
         check("t2 hold", if_pc, 32'h0000_3004);
      end
      id_stall = 1'b0;
      step();
      check("t2 buf pc", if_pc, 32'h0000_3008);
      check("t2 buf ir", if_ir, 32'h3008_0000);
      check("t2 next", imem_addr, 32'h0000_300C);
      step();
      check("t2 pc", if_pc, 32'h0000_300C);
      check("t2 addr", imem_addr, 32'h0000_3010);

      // Redirect with request outstanding: drain the stale fetch first.
      imem_ack       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3100;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t3 stale addr", imem_addr, 32'h0000_3010);
         check("t3 novalid", {31'd0, if_valid}, 32'd0);
         if (i < 2) step();
      end
      imem_ack = 1'b1;
      step();
      check("t3 target", imem_addr, 32'h0000_3100);
      check("t3 dropped", {31'd0, if_valid}, 32'd0);
      step();
      check("t3 pc", if_pc, 32'h0000_3100);
      check("t3 ir", if_ir, 32'h3100_0000);

      // Redirect coincident with ack; misaligned target.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3010;
      step();
      check("t4 addr", imem_addr, 32'h0000_3010);
      check("t4 novalid", {31'd0, if_valid}, 32'd0);
      redirect_pc = 32'h0000_3103;
      step();
      redirect_valid = 1'b0;
      check("t4 dropped", {31'd0, if_valid}, 32'd0);
      check("t4 align", imem_addr, 32'h0000_3100);
      step();
      check("t4 pc", if_pc, 32'h0000_3100);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      check("t5 addr", imem_addr, 32'hFFFF_FFFC);
      step();
      check("t5 pc", if_pc, 32'hFFFF_FFFC);
      check("t5 pc4", if_pc4, 32'h0000_0000);
      check("t5 ir", if_ir, 32'hFFFC_FFFF);
      check("t5 wrap", imem_addr, 32'h0000_0000);
      step();
      check("t5 pc0", if_pc, 32'h0000_0000);
      check("t5 pc4b", if_pc4, 32'h0000_0004);

      // Async reset in DRAIN, stale ack arriving around it.
      imem_ack       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3200;
      step();
      redirect_valid = 1'b0;
      check("t6 drain req", {31'd0, imem_req}, 32'd1);
      check("t6 drain addr", imem_addr, 32'h0000_0004);
      imem_ack = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("t6 rst req", {31'd0, imem_req}, 32'd0);
      check("t6 rst valid", {31'd0, if_valid}, 32'd0);
      check("t6 rst addr", imem_addr, 32'h0000_3000);
      step();
      rst = 1'b0;
      step();
      check("t6 first addr", imem_addr, 32'h0000_3000);
      check("t6 novalid", {31'd0, if_valid}, 32'd0);
      step();
      check("t6 pc", if_pc, 32'h0000_3000);
      check("t6 ir", if_ir, 32'h3000_0000);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         step();
         imem_ack       = ($urandom_range(0, 3) != 0);
         id_stall       = ($urandom_range(0, 2) == 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
         salt           = $urandom;
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            step();
            rst = 1'b0;
         end
      end
      step();
      model_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
